// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Definitions shared by the overworld and battle blocks.
//   battle_state_t      : encounter sequencing states. The encoding is the
//                         2-bit battle_bit value read by the map scroller.
//   GRASS_INDEX_DEFAULT : palette index of grass tiles.
//   KEY_*               : keyboard scan codes used by the game logic.
//   LFSR_MASK/lfsr_next : 16-bit Galois LFSR, taps 16,14,13,11.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ROAM       = 2'd0,
        TRANSITION = 2'd1,
        BATTLE     = 2'd2,
        COOLDOWN   = 2'd3
    } battle_state_t;

    localparam logic [3:0] GRASS_INDEX_DEFAULT = 4'd13;

    // USB HID keyboard scan codes
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Right-shifting Galois form: the bit shifted out is fed back through the mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/encounter_ctrl_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR. Also used by the battle screen for damage rolls.
//   frame_clk in  1  : clock
//   Reset     in  1  : synchronous, active-high; loads SEED
//   enable    in  1  : advance one step on this edge
//   state     out 16 : current LFSR contents
// SEED must be nonzero, otherwise the register stays at zero.
// -----------------------------------------------------------------------------
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        enable,
    output logic [15:0] state
);

    // NOTE: sequential state is written with <= so every flop in the design
    //       samples pre-edge values, regardless of the order of the always blocks.
    always_ff @(posedge frame_clk) begin
        if (Reset)
            state <= SEED;
        else if (enable)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/encounter_ctrl.sv
// -----------------------------------------------------------------------------
// encounter_ctrl
// Overworld wild-encounter controller. Counts the pixels the player scrolls
// on grass. Each completed step rolls the LFSR, and a hit sequences
// TRANSITION -> BATTLE -> COOLDOWN -> ROAM.
//   frame_clk     in  1  : one edge per video frame
//   Reset         in  1  : synchronous, active-high
//   FrameX        in  10 : map scroll X from the scroller
//   FrameY        in  10 : map scroll Y from the scroller
//   pelette_index in  4  : palette index of the tile under the player
//   battle_done   in  1  : one-frame pulse when the battle screen exits
//   battle_bit    out 2  : 0 ROAM, 1 TRANSITION, 2 BATTLE, 3 COOLDOWN
//   flash         out 1  : screen flash enable, active only in TRANSITION
//   encounter_id  out 3  : species index, latched when the encounter triggers
// All outputs come from registers only.
// -----------------------------------------------------------------------------
module encounter_ctrl
    import game_pkg::*;
#(
    parameter logic [3:0]  GRASS_INDEX      = GRASS_INDEX_DEFAULT,
    parameter int          STEP_PIXELS      = 16,
    parameter logic [8:0]  ENCOUNTER_THRESH = 9'd26,
    parameter int          TRANS_FRAMES     = 60,
    parameter int          COOLDOWN_STEPS   = 8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] FrameX,
    input  logic [9:0] FrameY,
    input  logic [3:0] pelette_index,
    input  logic       battle_done,
    output logic [1:0] battle_bit,
    output logic       flash,
    output logic [2:0] encounter_id
);

    localparam int PIX_W   = $clog2(STEP_PIXELS);
    // The flash pattern uses trans_cnt[3], so the counter is always at least 4 bits wide.
    localparam int TRANS_W = ($clog2(TRANS_FRAMES) > 4) ? $clog2(TRANS_FRAMES) : 4;
    localparam int STEP_W  = $clog2(COOLDOWN_STEPS + 1);

    battle_state_t      state;
    battle_state_t      state_next;
    logic [9:0]         prev_x;
    logic [9:0]         prev_y;
    logic [PIX_W-1:0]   pix_cnt;
    logic [TRANS_W-1:0] trans_cnt;
    logic [STEP_W-1:0]  step_cnt;
    logic [15:0]        lfsr;

    logic moved;
    logic on_grass;
    logic pix_wrap;
    logic roll_hit;
    logic trans_last;
    logic cool_last;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .enable    (1'b1),
        .state     (lfsr)
    );

    // Bits above the species field are not used by this block. They are
    // folded into one signal so it is clear they are left unused on purpose.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[15:11];

    // The scroller moves at most 1 px per frame, so any change in position means one pixel walked.
    assign moved      = (FrameX != prev_x) || (FrameY != prev_y);
    assign on_grass   = (pelette_index == GRASS_INDEX);
    assign pix_wrap   = (pix_cnt == PIX_W'(STEP_PIXELS - 1));
    // Grass step completed in ROAM, and the roll uses the LFSR value from before this edge.
    assign roll_hit   = (state == ROAM) && moved && on_grass && pix_wrap &&
                        ({1'b0, lfsr[7:0]} < ENCOUNTER_THRESH);
    assign trans_last = (trans_cnt == TRANS_W'(TRANS_FRAMES - 1));
    assign cool_last  = (step_cnt == STEP_W'(COOLDOWN_STEPS - 1));

    // ---------------- state register ----------------
    always_ff @(posedge frame_clk) begin
        if (Reset)
            state <= ROAM;
        else
            state <= state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every variable assigned in always_comb gets a default first, so
    //       paths that do not assign it cannot infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ROAM:       if (roll_hit)                    state_next = TRANSITION;
            TRANSITION: if (trans_last)                  state_next = BATTLE;
            BATTLE:     if (battle_done)                 state_next = COOLDOWN;
            COOLDOWN:   if (moved && pix_wrap && cool_last) state_next = ROAM;
            default:                                     state_next = ROAM;
        endcase
    end

    // ---------------- outputs (decoded from registers only) ----------------
    always_comb begin
        battle_bit = state;
        flash      = (state == TRANSITION) && trans_cnt[3];
    end

    // ---------------- counters and encounter latch ----------------
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_x       <= '0;
            prev_y       <= '0;
            pix_cnt      <= '0;
            trans_cnt    <= '0;
            step_cnt     <= '0;
            encounter_id <= '0;
        end else begin
            prev_x <= FrameX;
            prev_y <= FrameY;
            unique case (state)
                ROAM: begin
                    if (roll_hit) begin
                        pix_cnt      <= '0;
                        trans_cnt    <= '0;
                        encounter_id <= lfsr[10:8];
                    end else if (moved && on_grass) begin
                        // An off-grass move leaves pix_cnt unchanged, so a partial step carries over.
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    end
                end
                TRANSITION: trans_cnt <= trans_cnt + TRANS_W'(1);
                BATTLE: begin
                    if (battle_done) begin
                        pix_cnt  <= '0;
                        step_cnt <= '0;
                    end
                end
                COOLDOWN: begin
                    if (moved) begin
                        // A power-of-two step length means the wrap leaves pix_cnt
                        // at zero on the final step, which is the value ROAM needs.
                        pix_cnt <= pix_cnt + PIX_W'(1);
                        if (pix_wrap)
                            step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encounter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encounter_ctrl
// Three encounter_ctrl instances share the same stimulus and use encounter
// thresholds of 0, 256 and 26. A frame-level reference model, written from
// the behavioural rules, tracks each instance on every frame. Table-driven
// segments and hand-written sequences check the THRESH=256 instance against
// constants.
// -----------------------------------------------------------------------------
module tb_encounter_ctrl;

    localparam int STEP   = 16;
    localparam int TRANS  = 60;
    localparam int COOLS  = 8;
    localparam int GRASS  = 13;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [9:0] FrameX    = '0;
    logic [9:0] FrameY    = '0;
    logic [3:0] pelette_index = 4'd0;
    logic       battle_done = 1'b0;

    logic [1:0] bits  [3];
    logic       flashes [3];
    logic [2:0] ids   [3];

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    encounter_ctrl #(.ENCOUNTER_THRESH(9'd0)) dut_never (
        .frame_clk(frame_clk), .Reset(Reset), .FrameX(FrameX), .FrameY(FrameY),
        .pelette_index(pelette_index), .battle_done(battle_done),
        .battle_bit(bits[0]), .flash(flashes[0]), .encounter_id(ids[0]));

    encounter_ctrl #(.ENCOUNTER_THRESH(9'd256)) dut_always (
        .frame_clk(frame_clk), .Reset(Reset), .FrameX(FrameX), .FrameY(FrameY),
        .pelette_index(pelette_index), .battle_done(battle_done),
        .battle_bit(bits[1]), .flash(flashes[1]), .encounter_id(ids[1]));

    encounter_ctrl dut_rand (
        .frame_clk(frame_clk), .Reset(Reset), .FrameX(FrameX), .FrameY(FrameY),
        .pelette_index(pelette_index), .battle_done(battle_done),
        .battle_bit(bits[2]), .flash(flashes[2]), .encounter_id(ids[2]));

    // ---------------- reference model ----------------
    typedef struct {
        int          mode;    // 0 roam, 1 transition, 2 battle, 3 cooldown
        int          pixels;  // pixels walked toward the current step
        int          frames;  // frames spent in the transition
        int          steps;   // steps completed in cooldown
        logic [15:0] lfsr;
        int          id;
        int          px;
        int          py;
    } model_t;

    model_t m [3];
    int     thresh [3] = '{0, 256, 26};

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return (s >> 1) ^ ((s & 16'h1) != 0 ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_frame(input int i, input bit rst, input int x, input int y,
                               input int tile, input bit done);
        bit          moved;
        bit          step;
        logic [15:0] roll;
        if (rst) begin
            m[i] = '{mode: 0, pixels: 0, frames: 0, steps: 0, lfsr: SEED, id: 0, px: 0, py: 0};
            return;
        end
        moved = (x != m[i].px) || (y != m[i].py);
        m[i].px = x;
        m[i].py = y;
        roll = m[i].lfsr;
        m[i].lfsr = lfsr_adv(m[i].lfsr);
        case (m[i].mode)
            0: if (moved && tile == GRASS) begin
                   m[i].pixels++;
                   if (m[i].pixels == STEP) begin
                       m[i].pixels = 0;
                       if (int'(roll[7:0]) < thresh[i]) begin
                           m[i].mode   = 1;
                           m[i].id     = int'(roll[10:8]);
                           m[i].frames = 0;
                       end
                   end
               end
            1: begin
                   m[i].frames++;
                   if (m[i].frames == TRANS) m[i].mode = 2;
               end
            2: if (done) begin
                   m[i].mode   = 3;
                   m[i].pixels = 0;
                   m[i].steps  = 0;
               end
            default: if (moved) begin
                   m[i].pixels++;
                   if (m[i].pixels == STEP) begin
                       m[i].pixels = 0;
                       m[i].steps++;
                       if (m[i].steps == COOLS) m[i].mode = 0;
                   end
               end
        endcase
    endtask

    function automatic logic [5:0] model_out(input int i);
        logic f;
        f = (m[i].mode == 1) && (((m[i].frames >> 3) & 1) == 1);
        return {m[i].mode[1:0], f, m[i].id[2:0]};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One frame: drive the inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic tick(input bit move, input bit move_y, input logic [3:0] tile,
                        input bit done, input bit rst);
        @(negedge frame_clk);
        if (rst) begin
            FrameX = '0;
            FrameY = '0;
        end else if (move) begin
            if (move_y) FrameY = FrameY + 10'd1;
            else        FrameX = FrameX + 10'd1;
        end
        pelette_index = tile;
        battle_done   = done;
        Reset         = rst;
        @(posedge frame_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            model_frame(i, rst, int'(FrameX), int'(FrameY), int'(tile), done);
            check($sformatf("model_dut%0d", i), {26'd0, bits[i], flashes[i], ids[i]},
                  {26'd0, model_out(i)});
        end
    endtask

    // ---------------- directed segment table ----------------
    typedef struct {
        string      name;
        int         frames;
        bit         move;
        logic [3:0] tile;
        bit         alt;      // alternate tile 2 / tile 13 each frame, starting with tile 2
        bit         done;
        logic [1:0] exp_bit;
        logic       exp_flash;
        bit         chk_id;
    } seg_t;

    seg_t segs [$];

    task automatic add(input string n, input int f, input bit mv, input int t, input bit a,
                       input bit d, input int eb, input bit ef, input bit ci);
        seg_t s;
        s.name = n; s.frames = f; s.move = mv; s.tile = 4'(t); s.alt = a; s.done = d;
        s.exp_bit = 2'(eb); s.exp_flash = ef; s.chk_id = ci;
        segs.push_back(s);
    endtask

    initial begin
        logic [15:0] ref_l;

        add("pre_step",       15, 1, 13, 0, 0, 0, 0, 0);
        add("trigger",         1, 1, 13, 0, 0, 1, 0, 1);
        add("flash_on",        8, 1, 13, 0, 0, 1, 1, 0);
        add("flash_off",       8, 0, 13, 0, 0, 1, 0, 0);
        add("trans_last",     43, 0,  2, 0, 0, 1, 1, 0);
        add("battle_entry",    1, 0,  2, 0, 0, 2, 0, 0);
        add("battle_hold",   500, 0,  2, 0, 0, 2, 0, 0);
        add("battle_done",     1, 0,  2, 0, 1, 3, 0, 0);
        add("cool_done_ign",   1, 0,  2, 0, 1, 3, 0, 0);
        add("cool_127",      127, 1,  2, 0, 0, 3, 0, 0);
        add("cool_128",        1, 1,  2, 0, 0, 0, 0, 0);
        add("offgrass_200",  200, 1,  2, 0, 0, 0, 0, 0);
        add("grass_10",       10, 1, 13, 0, 0, 0, 0, 0);
        add("offgrass_hold",  20, 1,  2, 0, 0, 0, 0, 0);
        add("grass_15",        5, 1, 13, 0, 0, 0, 0, 0);
        add("grass_16",        1, 1, 13, 0, 0, 1, 0, 1);
        add("to_battle",      60, 0, 13, 0, 0, 2, 0, 0);
        add("battle_done2",    1, 0, 13, 0, 1, 3, 0, 0);
        add("cool_grass_128",128, 1, 13, 0, 0, 0, 0, 0);
        add("alt_31",         31, 1,  2, 1, 0, 0, 0, 0);
        add("alt_32",          1, 1, 13, 0, 0, 1, 0, 1);

        // Reset state
        tick(0, 0, 4'd13, 0, 1);
        tick(0, 0, 4'd13, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_bit%0d", i),   {30'd0, bits[i]},    32'd0);
            check($sformatf("reset_flash%0d", i), {31'd0, flashes[i]}, 32'd0);
            check($sformatf("reset_id%0d", i),    {29'd0, ids[i]},     32'd0);
        end

        // THRESH=0 never triggers
        for (int k = 0; k < 100; k++) tick(1, 0, 4'd13, 0, 0);
        check("never_100_grass", {30'd0, bits[0]}, 32'd0);

        // Table segments, checked against constants on the THRESH=256 instance.
        // The first segment starts from a freshly reset instance.
        tick(0, 0, 4'd13, 0, 1);
        foreach (segs[s]) begin
            for (int k = 0; k < segs[s].frames; k++)
                tick(segs[s].move, 0,
                     segs[s].alt ? ((k % 2 == 0) ? 4'd2 : 4'd13) : segs[s].tile,
                     segs[s].done, 0);
            check({segs[s].name, "_bit"},   {30'd0, bits[1]},    {30'd0, segs[s].exp_bit});
            check({segs[s].name, "_flash"}, {31'd0, flashes[1]}, {31'd0, segs[s].exp_flash});
            if (segs[s].chk_id)
                check({segs[s].name, "_id"}, {29'd0, ids[1]}, {29'd0, m[1].id[2:0]});
        end
        check("never_after_table", {30'd0, bits[0]}, 32'd0);

        // Reset in the middle of TRANSITION
        tick(0, 0, 4'd13, 0, 1);
        for (int k = 0; k < 16; k++) tick(1, 0, 4'd13, 0, 0);
        check("midreset_pre_bit", {30'd0, bits[1]}, 32'd1);
        for (int k = 0; k < 29; k++) tick(0, 0, 4'd13, 0, 0);
        tick(0, 0, 4'd13, 0, 1);
        check("midreset_bit",   {30'd0, bits[1]},    32'd0);
        check("midreset_flash", {31'd0, flashes[1]}, 32'd0);
        // After reset the LFSR should hold the seed. The id latched by the next
        // trigger comes from the seed advanced 15 times, computed here without the model.
        ref_l = SEED;
        for (int k = 0; k < 15; k++) ref_l = lfsr_adv(ref_l);
        for (int k = 0; k < 16; k++) tick(1, 0, 4'd13, 0, 0);
        check("midreset_retrig_bit", {30'd0, bits[1]}, 32'd1);
        check("midreset_seed_id",    {29'd0, ids[1]},  {29'd0, ref_l[10:8]});

        // Randomized stimulus; every frame is compared against the model inside tick
        for (int n = 0; n < 6000; n++) begin
            tick($urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 1) == 1) ? 4'd13 : 4'($urandom_range(0, 15)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 999) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
